// File: rtl/axis_in_fifo.sv
// axis_in_fifo: buffered AXI-Stream input stage, 64-bit beats.
//
// The FIFO sits between the DMA read channel and the accelerator stream slave.
// It is first-word fall-through: the head entry is held in a reset-cleared
// register, so the m_* outputs are always registers.
//
// The FIFO counts buffered beats (level) and complete TLAST-terminated frames
// (frames).
//
// Optional feature, selected by macro AXIS_IN_FIFO_STORE_FWD_EN:
//   defined     - store-and-forward. m_tvalid rises only once a complete frame
//                 is resident, or once the buffer is full. The full case lets an
//                 oversized frame out in cut-through so the FIFO cannot deadlock.
//   not defined - pure cut-through. m_tvalid = (level != 0).
module axis_in_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic [63:0]   s_tdata,
    input  logic [7:0]    s_tstrb,
    input  logic          s_tlast,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [63:0]   m_tdata,
    output logic [7:0]    m_tstrb,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [AW:0]   level,
    output logic [AW:0]   frames
);

    localparam int          EW       = 73;               // {tlast, tstrb[7:0], tdata[63:0]}
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    // Storage and state
    logic [EW-1:0] mem_r [DEPTH];
    logic [EW-1:0] head_r;
    logic [AW-1:0] wp_r;
    logic [AW-1:0] rp_r;
    logic [AW:0]   level_r;
    logic [AW:0]   frames_r;
    logic          s_tready_r;
    logic          m_tvalid_r;

    // Next-state and handshake signals
    logic          push_s;
    logic          pop_s;
    logic [AW-1:0] rp_inc_s;
    logic [AW-1:0] rp_nxt_s;
    logic [AW-1:0] wp_nxt_s;
    logic [AW:0]   level_nxt_s;
    logic [AW:0]   frames_nxt_s;
    logic [EW-1:0] head_nxt_s;
    logic [EW-1:0] din_s;
    logic          s_tready_nxt_s;
    logic          m_tvalid_nxt_s;
    logic          frame_in_s;
    logic          frame_out_s;

    assign din_s = {s_tlast, s_tstrb, s_tdata};

    // Handshakes use only registered ready/valid, so there is no m_tready -> s_tready path
    always_comb begin
        push_s      = s_tvalid & s_tready_r;
        pop_s       = m_tvalid_r & m_tready;
        frame_in_s  = push_s & s_tlast;
        frame_out_s = pop_s & head_r[EW-1];
        rp_inc_s    = rp_r + PTR_ONE;
    end

    // Pointer, beat-count and frame-count next state; clear overrides any handshake
    always_comb begin
        wp_nxt_s     = wp_r;
        rp_nxt_s     = rp_r;
        level_nxt_s  = level_r;
        frames_nxt_s = frames_r;
        if (clear) begin
            wp_nxt_s     = {AW{1'b0}};
            rp_nxt_s     = {AW{1'b0}};
            level_nxt_s  = CNT_ZERO;
            frames_nxt_s = CNT_ZERO;
        end else begin
            if (push_s) begin
                wp_nxt_s = wp_r + PTR_ONE;
            end else begin
                wp_nxt_s = wp_r;
            end
            if (pop_s) begin
                rp_nxt_s = rp_inc_s;
            end else begin
                rp_nxt_s = rp_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_nxt_s = level_r + CNT_ONE;
                2'b01:   level_nxt_s = level_r - CNT_ONE;
                default: level_nxt_s = level_r;
            endcase
            case ({frame_in_s, frame_out_s})
                2'b10:   frames_nxt_s = frames_r + CNT_ONE;
                2'b01:   frames_nxt_s = frames_r - CNT_ONE;
                default: frames_nxt_s = frames_r;
            endcase
        end
    end

    // Head register tracks the entry at the read pointer. A beat written into the
    // slot that becomes the head is bypassed straight in. Otherwise the head
    // reloads only on a pop, so stale content stays stable while the FIFO is empty.
    always_comb begin
        head_nxt_s = head_r;
        if (clear) begin
            head_nxt_s = {EW{1'b0}};
        end else if (push_s && (wp_r == rp_nxt_s)) begin
            head_nxt_s = din_s;
        end else if (pop_s) begin
            head_nxt_s = mem_r[rp_inc_s];
        end else begin
            head_nxt_s = head_r;
        end
    end

    // Output flag next state, computed from the post-edge counts
    always_comb begin
        s_tready_nxt_s = (level_nxt_s != CNT_FULL);
`ifdef AXIS_IN_FIFO_STORE_FWD_EN
        m_tvalid_nxt_s = (frames_nxt_s != CNT_ZERO) | (level_nxt_s == CNT_FULL);
`else
        m_tvalid_nxt_s = (level_nxt_s != CNT_ZERO);
`endif
    end

    // Beat storage: written on an accepted push unless a flush is in progress (not reset)
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_r[wp_r] <= din_s;
        end else begin
            mem_r[wp_r] <= mem_r[wp_r];
        end
    end

    // Control state and registered outputs, async reset to the empty state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_r       <= {AW{1'b0}};
            rp_r       <= {AW{1'b0}};
            level_r    <= CNT_ZERO;
            frames_r   <= CNT_ZERO;
            head_r     <= {EW{1'b0}};
            s_tready_r <= 1'b1;
            m_tvalid_r <= 1'b0;
        end else begin
            wp_r       <= wp_nxt_s;
            rp_r       <= rp_nxt_s;
            level_r    <= level_nxt_s;
            frames_r   <= frames_nxt_s;
            head_r     <= head_nxt_s;
            s_tready_r <= s_tready_nxt_s;
            m_tvalid_r <= m_tvalid_nxt_s;
        end
    end

    assign s_tready = s_tready_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tlast  = head_r[EW-1];
    assign m_tstrb  = head_r[71:64];
    assign m_tdata  = head_r[63:0];
    assign level    = level_r;
    assign frames   = frames_r;

endmodule

// File: tb/tb_axis_in_fifo.sv
// Scoreboard bench for axis_in_fifo (DEPTH=16). Each accepted input beat is
// queued. A negedge monitor pops the queue and compares on every output handshake.
module tb_axis_in_fifo;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  level;
    logic [4:0]  frames;

    int n_cmp = 0;
    int n_err = 0;
    logic [72:0] sb_q [$];
    logic [72:0] sb_exp;

    axis_in_fifo #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .level(level), .frames(frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop and compare on output handshakes, then enqueue accepted input beats
    always @(negedge clk) begin
        if (reset || clear) begin
            sb_q.delete();
        end else begin
            if (m_tvalid && m_tready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_underflow: got %h with no beat expected", {m_tlast, m_tstrb, m_tdata});
                end else begin
                    sb_exp = sb_q.pop_front();
                    if ({m_tlast, m_tstrb, m_tdata} !== sb_exp) begin
                        n_err++;
                        $display("FAIL sb_beat: got %h expected %h", {m_tlast, m_tstrb, m_tdata}, sb_exp);
                    end
                end
            end
            if (s_tvalid && s_tready) begin
                sb_q.push_back({s_tlast, s_tstrb, s_tdata});
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] st, input logic l);
        int  n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        s_tdata  = d;
        s_tstrb  = st;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (!acc && n < 50) begin
            acc = s_tready;
            step();
            n++;
        end
        s_tvalid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: got no accept expected accept of %0h", d);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (level != 5'd0 && n < 200) begin
            step();
            n++;
        end
        chk(name, 64'(level), 64'd0);
        m_tready = 1'b0;
    endtask

    initial begin
        int bubbles;
        int lvl_bad;
        reset = 1'b1; clear = 1'b0; m_tready = 1'b0;
        s_tvalid = 1'b1; s_tdata = 64'h0; s_tstrb = 8'h0; s_tlast = 1'b0;

        // Reset with s_tvalid high
        step(); step(); step();
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_level",    64'(level),    64'd0);
        chk("rst_frames",   64'(frames),   64'd0);
        chk("rst_m_tdata",  m_tdata,       64'd0);
        chk("rst_m_tstrb",  64'(m_tstrb),  64'd0);
        chk("rst_m_tlast",  64'(m_tlast),  64'd0);
        reset = 1'b0; s_tvalid = 1'b0;
        step();
        chk("post_rst_level", 64'(level), 64'd0);

        // Three-beat frame, downstream stalled
        push_beat(64'h1, 8'h0F, 1'b0);
        chk("first_m_tdata", m_tdata, 64'h1);
`ifdef AXIS_IN_FIFO_STORE_FWD_EN
        chk("first_m_tvalid", 64'(m_tvalid), 64'd0);
`else
        chk("first_m_tvalid", 64'(m_tvalid), 64'd1);
`endif
        push_beat(64'h2, 8'hF0, 1'b0);
        push_beat(64'h3, 8'hFF, 1'b1);
        chk("three_level",  64'(level),  64'd3);
        chk("three_frames", 64'(frames), 64'd1);
        chk("three_m_tvalid", 64'(m_tvalid), 64'd1);
        wait_drain("three_drain");
        chk("three_frames_end", 64'(frames), 64'd0);

        // Fill to full, hold the 17th beat, then free one slot
        for (int i = 0; i < 16; i++) begin
            push_beat(64'h100 + 64'(i), 8'(i), (i == 15));
        end
        chk("full_s_tready", 64'(s_tready), 64'd0);
        chk("full_level",    64'(level),    64'd16);
        s_tdata = 64'h1FF; s_tstrb = 8'hA5; s_tlast = 1'b1; s_tvalid = 1'b1;
        step(); step(); step();
        chk("held_level", 64'(level), 64'd16);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        chk("freed_s_tready", 64'(s_tready), 64'd1);
        chk("freed_level",    64'(level),    64'd15);
        step();
        s_tvalid = 1'b0;
        chk("refill_level",  64'(level),  64'd16);
        chk("refill_frames", 64'(frames), 64'd2);
        wait_drain("full_drain");

        // Continuous streaming across pointer wrap
        m_tready = 1'b1;
        bubbles  = 0;
        lvl_bad  = 0;
        for (int i = 0; i < 40; i++) begin
            push_beat(64'h3000 + 64'(i), 8'(i), (i % 8 == 7));
            if (!m_tvalid) bubbles++;
            if (level != 5'd1) lvl_bad++;
        end
`ifndef AXIS_IN_FIFO_STORE_FWD_EN
        chk("stream_bubbles", 64'(bubbles), 64'd0);
        chk("stream_level_off_1", 64'(lvl_bad), 64'd0);
        step();
        chk("stream_end_level", 64'(level), 64'd0);
`endif
        wait_drain("stream_drain");
        chk("stream_end_frames", 64'(frames), 64'd0);

        // Clear at level 5 with a simultaneous push
        for (int i = 0; i < 5; i++) begin
            push_beat(64'h500 + 64'(i), 8'h3C, (i == 2));
        end
        chk("pre_clear_level", 64'(level), 64'd5);
        s_tdata = 64'hDEAD; s_tstrb = 8'hFF; s_tlast = 1'b1; s_tvalid = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0; s_tvalid = 1'b0;
        chk("clear_level",    64'(level),    64'd0);
        chk("clear_frames",   64'(frames),   64'd0);
        chk("clear_m_tvalid", 64'(m_tvalid), 64'd0);
        push_beat(64'h51, 8'h11, 1'b0);
        push_beat(64'h52, 8'h22, 1'b1);
        wait_drain("clear_drain");

`ifdef AXIS_IN_FIFO_STORE_FWD_EN
        // Store-and-forward gating and the full-buffer escape
        for (int i = 0; i < 4; i++) begin
            push_beat(64'h600 + 64'(i), 8'h01, 1'b0);
        end
        chk("sf_partial_m_tvalid", 64'(m_tvalid), 64'd0);
        push_beat(64'h604, 8'h01, 1'b1);
        chk("sf_frame_m_tvalid", 64'(m_tvalid), 64'd1);
        wait_drain("sf_frame_drain");
        for (int i = 0; i < 16; i++) begin
            push_beat(64'h700 + 64'(i), 8'h02, 1'b0);
        end
        chk("sf_escape_m_tvalid", 64'(m_tvalid), 64'd1);
        m_tready = 1'b1;
        step();
        chk("sf_escape_pop_level", 64'(level), 64'd15);
        push_beat(64'h7FF, 8'h03, 1'b1);
        wait_drain("sf_escape_drain");
`else
        for (int i = 0; i < 4; i++) begin
            push_beat(64'h600 + 64'(i), 8'h01, 1'b0);
        end
        chk("ct_partial_m_tvalid", 64'(m_tvalid), 64'd1);
        wait_drain("ct_partial_drain");
`endif

        // Asynchronous reset mid-frame
        for (int i = 0; i < 7; i++) begin
            push_beat(64'h800 + 64'(i), 8'hC3, 1'b0);
        end
        chk("pre_areset_level", 64'(level), 64'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_s_tready", 64'(s_tready), 64'd1);
        chk("areset_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("areset_level",    64'(level),    64'd0);
        chk("areset_frames",   64'(frames),   64'd0);
        chk("areset_m_tdata",  m_tdata,       64'd0);
        chk("areset_m_tstrb",  64'(m_tstrb),  64'd0);
        chk("areset_m_tlast",  64'(m_tlast),  64'd0);
        step();
        reset = 1'b0;
        step();
        push_beat(64'h901, 8'h5A, 1'b1);
        chk("after_areset_m_tdata", m_tdata, 64'h901);
        wait_drain("after_areset_drain");

        step();
        chk("sb_left_over", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
